calendar_set_ctrl: RTL

CALENDAR_SET_CTRL -- requirements
Module: calendar_set_ctrl

---
 rtl/calendar_set_ctrl_if.sv | 22 ++
 rtl/calendar_set_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/calendar_set_ctrl_if.sv
// rtl/calendar_set_ctrl_if.sv - button/timebase inputs and edit-control outputs of the calendar set controller
interface calendar_set_ctrl_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [2:0] inc_manual;
    logic [2:0] dec_manual;
    logic [1:0] field_sel;
    logic       run_en;
    logic       blink;

    modport master (
        output tick, btn_mode, btn_up, btn_down,
        input  inc_manual, dec_manual, field_sel, run_en, blink
    );

    modport slave (
        input  tick, btn_mode, btn_up, btn_down,
        output inc_manual, dec_manual, field_sel, run_en, blink
    );
endinterface

// File: rtl/calendar_set_ctrl.sv
// rtl/calendar_set_ctrl.sv - calendar set-mode FSM with edit strobes, timeout and blink; CALENDAR_AUTO_REPEAT_EN adds held-button auto-repeat
module calendar_set_ctrl #(
    parameter int TIMEOUT_TICKS = 100,
    parameter int REPEAT_DELAY  = 5,
    parameter int REPEAT_RATE   = 2
) (
    input logic             clk,
    input logic             rst_n,
    calendar_set_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DAY   = 2'd1;
    localparam logic [1:0] ST_MONTH = 2'd2;
    localparam logic [1:0] ST_YEAR  = 2'd3;

    localparam int TW          = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int BLINK_TICKS = 5;
    localparam int BCW         = $clog2(BLINK_TICKS);

    logic [1:0]     state_q, state_d;
    logic           mode_prev_q, up_prev_q, down_prev_q;
    logic [2:0]     inc_q, inc_d, dec_q, dec_d;
    logic [TW-1:0]  idle_q, idle_d;
    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blink_q, blink_d;

    logic       mode_rise, up_rise, down_rise, any_btn, in_set;
    logic       state_change, rep_fire;
    logic [2:0] field_onehot;

    assign mode_rise    = bus.btn_mode & ~mode_prev_q;
    assign up_rise      = bus.btn_up   & ~up_prev_q;
    assign down_rise    = bus.btn_down & ~down_prev_q;
    assign any_btn      = bus.btn_mode | bus.btn_up | bus.btn_down;
    assign in_set       = (state_q != ST_RUN);
    assign state_change = (state_d != state_q);

    always_comb begin
        field_onehot = 3'b000;
        case (state_q)
            ST_DAY:   field_onehot = 3'b001;
            ST_MONTH: field_onehot = 3'b010;
            ST_YEAR:  field_onehot = 3'b100;
            default:  field_onehot = 3'b000;
        endcase
    end

    // Idle counter stops one short of TIMEOUT_TICKS: the tick that would reach it drops back to RUN.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        if (mode_rise) begin
            state_d = state_q + 2'd1;
        end
        if (!in_set || any_btn) begin
            idle_d = '0;
        end else if (bus.tick) begin
            if (idle_q >= TW'(TIMEOUT_TICKS - 1)) begin
                idle_d  = '0;
                state_d = ST_RUN;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

`ifdef CALENDAR_AUTO_REPEAT_EN
    localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    logic [HW-1:0] hold_q, hold_d, hold_limit;
    logic          rep_phase_q, rep_phase_d;

    always_comb begin
        hold_d      = hold_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        hold_limit  = rep_phase_q ? HW'(REPEAT_RATE - 1) : HW'(REPEAT_DELAY - 1);
        if (!in_set || state_change || up_rise || down_rise || !(bus.btn_up ^ bus.btn_down)) begin
            hold_d      = '0;
            rep_phase_d = 1'b0;
        end else if (bus.tick) begin
            if (hold_q >= hold_limit) begin
                rep_fire    = 1'b1;
                hold_d      = '0;
                rep_phase_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q      <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Edges take priority over auto-repeat; a mode edge or opposing edges suppress any strobe.
    always_comb begin
        inc_d       = 3'b000;
        dec_d       = 3'b000;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (in_set && !mode_rise) begin
            if (up_rise && !down_rise) begin
                inc_d = field_onehot;
            end else if (down_rise && !up_rise) begin
                dec_d = field_onehot;
            end else if (rep_fire) begin
                if (bus.btn_up) inc_d = field_onehot;
                else            dec_d = field_onehot;
            end
        end
        if (state_d == ST_RUN) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (state_change) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (bus.tick) begin
            if (blink_cnt_q >= BCW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            mode_prev_q <= 1'b1;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
            inc_q       <= 3'b000;
            dec_q       <= 3'b000;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= bus.btn_mode;
            up_prev_q   <= bus.btn_up;
            down_prev_q <= bus.btn_down;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    a_cfg_valid: assert property (@(posedge clk)
        (TIMEOUT_TICKS >= 1) && (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1));

    assign bus.inc_manual = inc_q;
    assign bus.dec_manual = dec_q;
    assign bus.field_sel  = state_q;
    assign bus.run_en     = (state_q == ST_RUN);
    assign bus.blink      = blink_q;
endmodule
